// File: rtl/id_ex_if.sv
// ID/EX stage bus: decoded ID fields, EX/MEM and MEM/WB writeback taps, EX outputs.
// master drives the ID/hazard side, slave is the pipeline register itself.
interface id_ex_if #(
    parameter int CNT_W = 16
);
    logic                stall;
    logic                flush;
    logic                id_valid;
    logic [4:0]          id_rs_addr;
    logic [4:0]          id_rt_addr;
    logic [4:0]          id_rd_addr;
    logic [31:0]         id_rs_data;
    logic [31:0]         id_rt_data;
    logic [3:0]          id_alu_op;
    logic [4:0]          id_shamt;
    logic                id_reg_write;
    logic                exmem_reg_write;
    logic [4:0]          exmem_rd_addr;
    logic [31:0]         exmem_result;
    logic                memwb_reg_write;
    logic [4:0]          memwb_rd_addr;
    logic [31:0]         memwb_result;

    logic signed [31:0]  ex_rs;
    logic [31:0]         ex_rs_unsigned;
    logic signed [31:0]  ex_rt;
    logic [31:0]         ex_rt_unsigned;
    logic [3:0]          ex_alu_op;
    logic [4:0]          ex_shamt;
    logic [4:0]          ex_rd_addr;
    logic                ex_reg_write;
    logic                ex_valid;
    logic [CNT_W-1:0]    bubble_count;

    modport master (
        output stall, flush, id_valid, id_rs_addr, id_rt_addr, id_rd_addr,
               id_rs_data, id_rt_data, id_alu_op, id_shamt, id_reg_write,
               exmem_reg_write, exmem_rd_addr, exmem_result,
               memwb_reg_write, memwb_rd_addr, memwb_result,
        input  ex_rs, ex_rs_unsigned, ex_rt, ex_rt_unsigned, ex_alu_op,
               ex_shamt, ex_rd_addr, ex_reg_write, ex_valid, bubble_count
    );

    modport slave (
        input  stall, flush, id_valid, id_rs_addr, id_rt_addr, id_rd_addr,
               id_rs_data, id_rt_data, id_alu_op, id_shamt, id_reg_write,
               exmem_reg_write, exmem_rd_addr, exmem_result,
               memwb_reg_write, memwb_rd_addr, memwb_result,
        output ex_rs, ex_rs_unsigned, ex_rt, ex_rt_unsigned, ex_alu_op,
               ex_shamt, ex_rd_addr, ex_reg_write, ex_valid, bubble_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU.
// Captures decoded fields on posedge clock, supports stall (hold) and flush
// (bubble), counts loaded bubbles with a saturating counter.
// Optional feature macro ID_EX_FWD_EN: operand forwarding from EX/MEM and
// MEM/WB at capture time, plus MEM/WB refresh of held operands during stall.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic    clock,
    input  logic    reset,
    id_ex_if.slave  bus
);
    logic [31:0]      r_rs;
    logic [31:0]      r_rt;
    logic [3:0]       r_alu_op;
    logic [4:0]       r_shamt;
    logic [4:0]       r_rd_addr;
    logic             r_reg_write;
    logic             r_valid;
    logic [4:0]       r_rs_addr;
    logic [4:0]       r_rt_addr;
    logic [CNT_W-1:0] r_count;

    logic [31:0]      w_rs_sel;
    logic [31:0]      w_rt_sel;
    logic             w_rs_refresh;
    logic             w_rt_refresh;
    logic [CNT_W-1:0] w_count_inc;

`ifdef ID_EX_FWD_EN
    // Operand source select (EX/MEM over MEM/WB, never $0) and held-operand refresh match
    always_comb begin
        w_rs_sel = bus.id_rs_data;
        if (bus.exmem_reg_write && bus.exmem_rd_addr == bus.id_rs_addr && bus.id_rs_addr != 5'd0)
            w_rs_sel = bus.exmem_result;
        else if (bus.memwb_reg_write && bus.memwb_rd_addr == bus.id_rs_addr && bus.id_rs_addr != 5'd0)
            w_rs_sel = bus.memwb_result;

        w_rt_sel = bus.id_rt_data;
        if (bus.exmem_reg_write && bus.exmem_rd_addr == bus.id_rt_addr && bus.id_rt_addr != 5'd0)
            w_rt_sel = bus.exmem_result;
        else if (bus.memwb_reg_write && bus.memwb_rd_addr == bus.id_rt_addr && bus.id_rt_addr != 5'd0)
            w_rt_sel = bus.memwb_result;

        w_rs_refresh = bus.memwb_reg_write && bus.memwb_rd_addr != 5'd0 && bus.memwb_rd_addr == r_rs_addr;
        w_rt_refresh = bus.memwb_reg_write && bus.memwb_rd_addr != 5'd0 && bus.memwb_rd_addr == r_rt_addr;
    end
`else
    // Without forwarding the register file values go straight through and held operands never change
    assign w_rs_sel     = bus.id_rs_data;
    assign w_rt_sel     = bus.id_rt_data;
    assign w_rs_refresh = 1'b0;
    assign w_rt_refresh = 1'b0;

    logic w_unused;
    assign w_unused = ^{bus.exmem_reg_write, bus.exmem_rd_addr, bus.exmem_result,
                        bus.memwb_reg_write, bus.memwb_rd_addr, r_rs_addr, r_rt_addr};
`endif

    // Bubble counter next value, sticking at all-ones
    assign w_count_inc = (r_count == {CNT_W{1'b1}}) ? r_count
                                                   : r_count + {{(CNT_W-1){1'b0}}, 1'b1};

    // Pipeline register: reset > flush > stall > load (bubble when ID is empty)
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rs        <= 32'd0;
            r_rt        <= 32'd0;
            r_alu_op    <= 4'd0;
            r_shamt     <= 5'd0;
            r_rd_addr   <= 5'd0;
            r_reg_write <= 1'b0;
            r_valid     <= 1'b0;
            r_rs_addr   <= 5'd0;
            r_rt_addr   <= 5'd0;
            r_count     <= {CNT_W{1'b0}};
        end else if (bus.flush || (!bus.stall && !bus.id_valid)) begin
            r_rs        <= 32'd0;
            r_rt        <= 32'd0;
            r_alu_op    <= 4'd0;
            r_shamt     <= 5'd0;
            r_rd_addr   <= 5'd0;
            r_reg_write <= 1'b0;
            r_valid     <= 1'b0;
            r_rs_addr   <= 5'd0;
            r_rt_addr   <= 5'd0;
            r_count     <= w_count_inc;
        end else if (bus.stall) begin
            if (r_valid) begin
                if (w_rs_refresh)
                    r_rs <= bus.memwb_result;
                if (w_rt_refresh)
                    r_rt <= bus.memwb_result;
            end
        end else begin
            r_rs        <= w_rs_sel;
            r_rt        <= w_rt_sel;
            r_alu_op    <= bus.id_alu_op;
            r_shamt     <= bus.id_shamt;
            r_rd_addr   <= bus.id_rd_addr;
            r_reg_write <= bus.id_reg_write;
            r_valid     <= 1'b1;
            r_rs_addr   <= bus.id_rs_addr;
            r_rt_addr   <= bus.id_rt_addr;
        end
    end

    assign bus.ex_rs          = r_rs;
    assign bus.ex_rs_unsigned = r_rs;
    assign bus.ex_rt          = r_rt;
    assign bus.ex_rt_unsigned = r_rt;
    assign bus.ex_alu_op      = r_alu_op;
    assign bus.ex_shamt       = r_shamt;
    assign bus.ex_rd_addr     = r_rd_addr;
    assign bus.ex_reg_write   = r_reg_write;
    assign bus.ex_valid       = r_valid;
    assign bus.bubble_count   = r_count;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (CNT_W = 4 so saturation is reachable quickly).
module tb_id_ex_stage;
    localparam int CNT_W = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    id_ex_if #(.CNT_W(CNT_W)) bus ();

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
        bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_rd_addr = 0;
        bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_alu_op = 0;
        bus.id_shamt = 0; bus.id_reg_write = 0;
        bus.exmem_reg_write = 0; bus.exmem_rd_addr = 0; bus.exmem_result = 0;
        bus.memwb_reg_write = 0; bus.memwb_rd_addr = 0; bus.memwb_result = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rs"},    bus.ex_rs_unsigned, 32'd0);
        chk({tag, "_rt"},    bus.ex_rt_unsigned, 32'd0);
        chk({tag, "_op"},    {28'd0, bus.ex_alu_op}, 32'd0);
        chk({tag, "_shamt"}, {27'd0, bus.ex_shamt}, 32'd0);
        chk({tag, "_rd"},    {27'd0, bus.ex_rd_addr}, 32'd0);
        chk({tag, "_rw"},    {31'd0, bus.ex_reg_write}, 32'd0);
        chk({tag, "_valid"}, {31'd0, bus.ex_valid}, 32'd0);
        chk({tag, "_cnt"},   {28'd0, bus.bubble_count}, 32'd0);
    endtask

    logic [31:0] exp_v;

    initial begin
        idle();
        #1;
        // 1: reset with random inputs
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            bus.stall = 1'($urandom); bus.flush = 1'($urandom); bus.id_valid = 1'($urandom);
            bus.id_rs_addr = 5'($urandom); bus.id_rt_addr = 5'($urandom);
            bus.id_rd_addr = 5'($urandom); bus.id_rs_data = $urandom;
            bus.id_rt_data = $urandom; bus.id_alu_op = 4'($urandom);
            bus.id_shamt = 5'($urandom); bus.id_reg_write = 1'($urandom);
            bus.memwb_reg_write = 1'($urandom); bus.memwb_rd_addr = 5'($urandom);
            bus.memwb_result = $urandom;
            step();
        end
        chk_zero("reset");
        reset = 0;
        idle();
        bus.id_valid = 1; bus.id_rs_addr = 1; bus.id_rt_addr = 2; bus.id_rd_addr = 4;
        bus.id_rs_data = 5; bus.id_rt_data = 7; bus.id_alu_op = 4'b0001;
        bus.id_shamt = 3; bus.id_reg_write = 1;
        step();
        chk("add_rs",    bus.ex_rs_unsigned, 32'd5);
        chk("add_rs_s",  bus.ex_rs, 32'd5);
        chk("add_rt",    bus.ex_rt_unsigned, 32'd7);
        chk("add_op",    {28'd0, bus.ex_alu_op}, 32'd1);
        chk("add_shamt", {27'd0, bus.ex_shamt}, 32'd3);
        chk("add_rd",    {27'd0, bus.ex_rd_addr}, 32'd4);
        chk("add_rw",    {31'd0, bus.ex_reg_write}, 32'd1);
        chk("add_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("add_cnt",   {28'd0, bus.bubble_count}, 32'd0);

        // 2: forwarding priority
        bus.id_rs_addr = 3; bus.id_rs_data = 32'h11;
        bus.exmem_reg_write = 1; bus.exmem_rd_addr = 3; bus.exmem_result = 32'hAAAA0000;
        bus.memwb_reg_write = 1; bus.memwb_rd_addr = 3; bus.memwb_result = 32'h1234;
        step();
`ifdef ID_EX_FWD_EN
        exp_v = 32'hAAAA0000;
`else
        exp_v = 32'h11;
`endif
        chk("fwd_exmem", bus.ex_rs_unsigned, exp_v);
        bus.exmem_reg_write = 0;
        step();
`ifdef ID_EX_FWD_EN
        exp_v = 32'h1234;
`else
        exp_v = 32'h11;
`endif
        chk("fwd_memwb", bus.ex_rs_unsigned, exp_v);
        bus.id_rs_addr = 0; bus.exmem_reg_write = 1; bus.exmem_rd_addr = 0;
        bus.memwb_rd_addr = 0;
        step();
        chk("fwd_r0", bus.ex_rs_unsigned, 32'h11);

        // 3: stall holds, MEM/WB refreshes held rt
        idle();
        bus.id_valid = 1; bus.id_rs_addr = 8; bus.id_rt_addr = 9; bus.id_rd_addr = 10;
        bus.id_rs_data = 32'h66; bus.id_rt_data = 32'h55; bus.id_alu_op = 4'b0010;
        bus.id_shamt = 1; bus.id_reg_write = 1;
        step();
        chk("ld_rt", bus.ex_rt_unsigned, 32'h55);
        bus.stall = 1; bus.id_rt_data = 32'h99; bus.id_rs_data = 32'h77;
        bus.id_alu_op = 4'b0111; bus.id_rd_addr = 12; bus.id_rt_addr = 13;
        bus.memwb_reg_write = 1; bus.memwb_rd_addr = 9; bus.memwb_result = 32'hDEAD;
        for (int i = 0; i < 3; i++) step();
`ifdef ID_EX_FWD_EN
        exp_v = 32'hDEAD;
`else
        exp_v = 32'h55;
`endif
        chk("stall_rt",    bus.ex_rt_unsigned, exp_v);
        chk("stall_rt_s",  bus.ex_rt, exp_v);
        chk("stall_rs",    bus.ex_rs_unsigned, 32'h66);
        chk("stall_op",    {28'd0, bus.ex_alu_op}, 32'd2);
        chk("stall_rd",    {27'd0, bus.ex_rd_addr}, 32'd10);
        chk("stall_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("stall_cnt",   {28'd0, bus.bubble_count}, 32'd0);

        // 4: flush beats stall
        idle();
        bus.stall = 1; bus.flush = 1; bus.id_valid = 1; bus.id_alu_op = 4'b0101;
        bus.id_reg_write = 1; bus.id_rs_data = 32'h3;
        step();
        chk("fl_op",    {28'd0, bus.ex_alu_op}, 32'd0);
        chk("fl_rw",    {31'd0, bus.ex_reg_write}, 32'd0);
        chk("fl_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("fl_rs",    bus.ex_rs_unsigned, 32'd0);
        chk("fl_cnt",   {28'd0, bus.bubble_count}, 32'd1);
        bus.flush = 0;
        step(); step();
        chk("stb_cnt",   {28'd0, bus.bubble_count}, 32'd1);
        chk("stb_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("stb_op",    {28'd0, bus.ex_alu_op}, 32'd0);
        idle();
        step();
        chk("empty_cnt",   {28'd0, bus.bubble_count}, 32'd2);
        chk("empty_valid", {31'd0, bus.ex_valid}, 32'd0);

        // 5: saturation (20 flushes starting from 2)
        bus.flush = 1;
        for (int i = 0; i < 12; i++) step();
        chk("sat_14", {28'd0, bus.bubble_count}, 32'd14);
        step();
        chk("sat_15", {28'd0, bus.bubble_count}, 32'd15);
        for (int i = 0; i < 7; i++) step();
        chk("sat_hold", {28'd0, bus.bubble_count}, 32'd15);

        // 6: reset during stall with valid contents
        idle();
        bus.id_valid = 1; bus.id_rs_addr = 2; bus.id_rt_addr = 3; bus.id_rd_addr = 7;
        bus.id_rs_data = 32'hCAFE; bus.id_rt_data = 32'hBEEF; bus.id_alu_op = 4'b0011;
        bus.id_shamt = 9; bus.id_reg_write = 1;
        step();
        chk("pre_valid", {31'd0, bus.ex_valid}, 32'd1);
        bus.stall = 1;
        step();
        chk("pre_rs", bus.ex_rs_unsigned, 32'hCAFE);
        reset = 1;
        step();
        chk_zero("midrst");
        reset = 0;
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
